// File: rtl/sprite_pkg.sv
// sprite_pkg: stmeta field layout, screen/texture geometry and emitter FSM states
package sprite_pkg;
  localparam int NUM_SPRITES = 128;
  localparam int ADDR_W      = 7;
  localparam int SCREEN_W    = 320;
  localparam int X_W         = 9;
  localparam int TEX_W       = 64;
  localparam int U_W         = 6;
  localparam int STMETA_W    = 120;
  localparam int TEX_LSB     = 112;
  localparam int SX_LSB      = 96;
  localparam int HGT_LSB     = 80;
  localparam int WID_LSB     = 64;
  localparam int DEP_LSB     = 48;
  localparam int YS_LSB      = 40;
  localparam int YE_LSB      = 32;
  typedef enum logic [3:0] {
    IDLE, RD_META, WAIT_META, DECODE, DIV, RD_ZB, WAIT_ZB, EMIT, NEXT_COL, NEXT_SPR, DONE
  } state_t;
  // Where a column walk goes next: past the last column ends the sprite, off-screen left is skipped
  function automatic state_t col_state(input logic signed [17:0] xv, input logic signed [17:0] last);
    return (xv > last) ? NEXT_SPR : ((xv < 0) ? NEXT_COL : RD_ZB);
  endfunction
endpackage

// File: rtl/sprite_col_emitter_if.sv
// sprite_col_emitter_if: scan control, stmeta/z-buffer read ports and column request channel
interface sprite_col_emitter_if;
  import sprite_pkg::*;
  logic                start;
  logic                done;
  logic [ADDR_W-1:0]   stmeta_raddr;
  logic [STMETA_W-1:0] stmeta_read_data;
  logic [X_W-1:0]      zb_raddr;
  logic [15:0]         zb_read_data;
  logic                col_valid;
  logic                col_ready;
  logic [X_W-1:0]      col_x;
  logic [7:0]          col_tex;
  logic [U_W-1:0]      col_u;
  logic [7:0]          col_y_start;
  logic [7:0]          col_y_end;
  modport master (
    input  start, stmeta_read_data, zb_read_data, col_ready,
    output done, stmeta_raddr, zb_raddr, col_valid, col_x, col_tex, col_u, col_y_start, col_y_end
  );
  modport slave (
    output start, stmeta_read_data, zb_read_data, col_ready,
    input  done, stmeta_raddr, zb_raddr, col_valid, col_x, col_tex, col_u, col_y_start, col_y_end
  );
endinterface

// File: rtl/seq_udiv.sv
// seq_udiv: 16/16 restoring unsigned divider, one quotient bit per cycle
module seq_udiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);
  logic [15:0] rem;
  logic [4:0]  cnt;
  logic [16:0] shifted, trial;
  assign shifted = {rem, quotient[15]};
  assign trial   = shifted - {1'b0, divisor};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem      <= '0;
      quotient <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        rem      <= '0;
        quotient <= dividend;
        cnt      <= 5'd16;
        busy     <= 1'b1;
      end else if (busy) begin
        rem      <= trial[16] ? shifted[15:0] : trial[15:0];
        quotient <= {quotient[14:0], ~trial[16]};
        cnt      <= cnt - 5'd1;
        busy     <= cnt != 5'd1;
        done     <= cnt == 5'd1;
      end
    end
endmodule

// File: rtl/sprite_col_emitter.sv
// sprite_col_emitter: scans stmeta slots, clips sprites to screen and z-buffer,
// and emits one column draw request per surviving screen column
module sprite_col_emitter
  import sprite_pkg::*;
(
  input logic clk,
  input logic rst,
  sprite_col_emitter_if.master bus
);
  localparam logic signed [17:0] X_MAX = 18'(SCREEN_W - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0]   slot;
  logic [STMETA_W-1:0] meta;
  logic signed [17:0]  x, x_last, x0, x1;
  logic [15:0]         u_fp, step, quo, width, depth, sx;
  logic [7:0]          tex;
  logic                div_start, div_done, unused_busy, unused_bits, skip, emit;
  assign tex         = meta[TEX_LSB +: 8];
  assign sx          = meta[SX_LSB +: 16];
  assign width       = meta[WID_LSB +: 16];
  assign depth       = meta[DEP_LSB +: 16];
  assign x0          = {{2{sx[15]}}, sx} - {3'b0, width[15:1]};
  assign x1          = x0 + {2'b0, width} - 18'd1;
  assign skip        = tex == 8'd0 || width == 16'd0 || depth[15] || depth == 16'd0;
  assign emit        = depth < bus.zb_read_data;
  assign unused_bits = ^{meta[HGT_LSB +: 16], meta[YE_LSB-1:0]};
  assign bus.done         = state == DONE;
  assign bus.stmeta_raddr = slot;
  assign bus.zb_raddr     = x[X_W-1:0];
  seq_udiv u_div (
    .clk(clk), .rst(rst), .start(div_start), .dividend(16'(TEX_W << 8)), .divisor(width),
    .busy(unused_busy), .done(div_done), .quotient(quo)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    case (state)
      IDLE:      state_nx = bus.start ? RD_META : IDLE;
      RD_META:   state_nx = WAIT_META;
      WAIT_META: state_nx = DECODE;
      DECODE: begin
        div_start = !skip;
        state_nx  = skip ? NEXT_SPR : DIV;
      end
      DIV:       state_nx = div_done ? col_state(x, x_last) : DIV;
      RD_ZB:     state_nx = WAIT_ZB;
      WAIT_ZB:   state_nx = emit ? EMIT : NEXT_COL;
      EMIT:      state_nx = bus.col_ready ? NEXT_COL : EMIT;
      NEXT_COL:  state_nx = col_state(x + 18'sd1, x_last);
      NEXT_SPR:  state_nx = (slot == ADDR_W'(NUM_SPRITES - 1)) ? DONE : RD_META;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      slot            <= '0;
      meta            <= '0;
      x               <= '0;
      x_last          <= '0;
      u_fp            <= '0;
      step            <= '0;
      bus.col_valid   <= 1'b0;
      bus.col_x       <= '0;
      bus.col_tex     <= '0;
      bus.col_u       <= '0;
      bus.col_y_start <= '0;
      bus.col_y_end   <= '0;
    end else begin
      if (state == IDLE) slot <= '0;
      if (state == NEXT_SPR) slot <= slot + ADDR_W'(1);
      if (state == WAIT_META) meta <= bus.stmeta_read_data;
      if (state == DECODE) begin
        x      <= x0;
        x_last <= (x1 > X_MAX) ? X_MAX : x1;
        u_fp   <= '0;
      end
      if (state == DIV && div_done) step <= quo;
      // u advances on every column, clipped ones included, so texture stays anchored to x0
      if (state == NEXT_COL) begin
        x    <= x + 18'sd1;
        u_fp <= u_fp + step;
      end
      if (state == WAIT_ZB && emit) begin
        bus.col_valid   <= 1'b1;
        bus.col_x       <= x[X_W-1:0];
        bus.col_tex     <= tex;
        bus.col_u       <= u_fp[8 +: U_W];
        bus.col_y_start <= meta[YS_LSB +: 8];
        bus.col_y_end   <= meta[YE_LSB +: 8];
      end
      if (state == EMIT && bus.col_ready) bus.col_valid <= 1'b0;
    end
endmodule

// File: tb/tb_sprite_col_emitter.sv
// tb_sprite_col_emitter: scoreboard bench; a behavioural clipping model fills the expected queue
module tb_sprite_col_emitter;
  import sprite_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  sprite_col_emitter_if bus();
  sprite_col_emitter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [STMETA_W-1:0] meta_mem [NUM_SPRITES];
  logic [15:0]         zb_mem [SCREEN_W];
  logic [38:0]         q [$];
  logic [38:0]         got;
  int n_cmp = 0, n_err = 0, done_cnt = 0, acc_cnt = 0, exp_n = 0;
  bit rnd_ready = 1'b0;
  assign got = {bus.col_x, bus.col_tex, bus.col_u, bus.col_y_start, bus.col_y_end};
  always @(posedge clk) begin
    bus.stmeta_read_data <= meta_mem[bus.stmeta_raddr];
    bus.zb_read_data     <= (int'(bus.zb_raddr) < SCREEN_W) ? zb_mem[bus.zb_raddr] : 16'h0;
  end
  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask
  always @(negedge clk) begin
    bus.col_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (bus.done) done_cnt++;
    if (bus.col_valid) begin
      chk("req_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) chk("payload", 64'(got), 64'(q[0]));
      if (bus.col_ready) begin
        acc_cnt++;
        if (q.size() > 0) void'(q.pop_front());
      end
    end
  end
  function automatic logic [STMETA_W-1:0] mk(input int tex, input int sx, input int w, input int dep, input int ys, input int ye);
    return {8'(tex), 16'(sx), 16'(w * 2), 16'(w), 16'(dep), 8'(ys), 8'(ye), 32'h0};
  endfunction
  task automatic load(input logic [15:0] zb_val);
    foreach (meta_mem[i]) meta_mem[i] = '0;
    foreach (zb_mem[i]) zb_mem[i] = zb_val;
  endtask
  task automatic build_model();
    q.delete();
    for (int s = 0; s < NUM_SPRITES; s++) begin
      int tex, sx, w, dep, ys, ye, step, u, xs;
      tex = int'(meta_mem[s][119:112]);
      sx  = int'($signed(meta_mem[s][111:96]));
      w   = int'(meta_mem[s][79:64]);
      dep = int'($signed(meta_mem[s][63:48]));
      ys  = int'(meta_mem[s][47:40]);
      ye  = int'(meta_mem[s][39:32]);
      if (tex == 0 || w == 0 || dep <= 0) continue;
      step = 16384 / w;
      u    = 0;
      xs   = sx - w / 2;
      for (int x = xs; x < xs + w && x < SCREEN_W; x++) begin
        if (x >= 0 && dep < int'(zb_mem[x])) q.push_back({9'(x), 8'(tex), 6'(u >> 8), 8'(ys), 8'(ye)});
        u = (u + step) & 32'hFFFF;
      end
    end
    exp_n = q.size();
  endtask
  task automatic run_scan(input string tag, input bit extra_start);
    int cyc = 0;
    build_model();
    acc_cnt  = 0;
    done_cnt = 0;
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
      bus.start = extra_start && cyc == 40;
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk({tag, "_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_count"}, 64'(acc_cnt), 64'(exp_n));
    chk({tag, "_left"}, 64'(q.size()), 64'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    load(16'hFFFF);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 64'(bus.col_valid), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_payload", 64'(got), 64'd0);
    chk("rst_raddr", 64'(bus.stmeta_raddr), 64'd0);
    @(negedge clk) rst = 1'b0;
    meta_mem[0] = mk(5, 160, 64, 16'h0200, 20, 100);
    run_scan("wide", 1'b0);
    chk("wide_n64", 64'(exp_n), 64'd64);
    load(16'hFFFF);
    meta_mem[0] = mk(5, 10, 64, 16'h0200, 20, 100);
    run_scan("left_clip", 1'b0);
    load(16'h0100);
    meta_mem[0] = mk(5, 160, 64, 16'h0200, 20, 100);
    run_scan("occluded", 1'b0);
    load(16'hFFFF);
    meta_mem[0] = mk(5, 160, 64, 16'h0200, 20, 100);
    rnd_ready = 1'b1;
    run_scan("stall", 1'b1);
    rnd_ready = 1'b0;
    load(16'hFFFF);
    foreach (zb_mem[i]) if (i % 2 == 1) zb_mem[i] = 16'h0100;
    meta_mem[1]   = mk(3, 300, 64, 16'h0200, 0, 239);
    meta_mem[2]   = mk(7, 100, 16, 16'h0000, 1, 2);
    meta_mem[4]   = mk(9, 50, 0, 16'h0200, 1, 2);
    meta_mem[6]   = mk(2, 200, 40, 16'h0180, 5, 6);
    meta_mem[9]   = mk(4, 100, 16, 16'hFF00, 1, 2);
    meta_mem[127] = mk(1, -5, 20, 16'h0050, 1, 2);
    run_scan("mixed", 1'b0);
    load(16'hFFFF);
    run_scan("empty1", 1'b0);
    run_scan("empty2", 1'b0);
    meta_mem[0] = mk(5, 160, 64, 16'h0200, 20, 100);
    build_model();
    acc_cnt  = 0;
    done_cnt = 0;
    @(negedge clk); #1 bus.start = 1'b1;
    @(negedge clk); #1 bus.start = 1'b0;
    for (int c = 0; c < 20000 && acc_cnt < 10; c++) begin
      @(negedge clk); #1;
    end
    chk("rst_reach10", 64'(acc_cnt), 64'd10);
    #2 rst = 1'b1;
    #1 chk("rst_mid_valid", 64'(bus.col_valid), 64'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    chk("rst_mid_no_done", 64'(done_cnt), 64'd0);
    run_scan("restart", 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
